// File: rtl/rst_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// rst_seq_pkg : shared types, defaults and helpers for the reset sequencer
// Rev 1.0
// ============================================================================
package rst_seq_pkg;

    typedef enum logic [1:0] {
        ST_HOLD    = 2'd0,
        ST_RELEASE = 2'd1,
        ST_RUN     = 2'd2
    } state_t;

    localparam int DEF_DEBOUNCE_CYC = 16;
    localparam int DEF_HOLD_CYC     = 8;
    localparam int DEF_STEP_CYC     = 4;
    localparam int DEF_STAGES       = 3;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rst_seq_ctrl_rst_sync_2ff.sv
`default_nettype none
// ============================================================================
// rst_sync_2ff : asynchronous-assert, synchronous-release reset synchronizer
// Rev 1.0
// ============================================================================
module rst_sync_2ff (
    input  logic clk,
    input  logic i_rst_n,
    output logic o_rst_n
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= 1'b1;
            r_sync <= r_meta;
        end
    end

    assign o_rst_n = r_sync;

endmodule
`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
`default_nettype none
// ============================================================================
// rst_seq_ctrl : merges power-on, push-button and software resets and
//                releases STAGES reset outputs in order after a hold delay
// Rev 1.0
// ============================================================================
module rst_seq_ctrl
    import rst_seq_pkg::*;
#(
    parameter int DEBOUNCE_CYC = DEF_DEBOUNCE_CYC,
    parameter int HOLD_CYC     = DEF_HOLD_CYC,
    parameter int STEP_CYC     = DEF_STEP_CYC,
    parameter int STAGES       = DEF_STAGES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              btn_n,
    input  logic              sw_rst_req,
    output logic              sw_rst_ack,
    output logic [STAGES-1:0] rst_out_n,
    output logic              busy
);

    localparam int c_HOLD_W = cnt_w(HOLD_CYC);
    localparam int c_STEP_W = cnt_w(STEP_CYC);
    localparam int c_DB_W   = cnt_w(DEBOUNCE_CYC);

    localparam logic [c_HOLD_W-1:0] c_HOLD_LAST = c_HOLD_W'(HOLD_CYC - 1);
    localparam logic [c_STEP_W-1:0] c_STEP_LAST = c_STEP_W'(STEP_CYC - 1);
    localparam logic [c_DB_W-1:0]   c_DB_LAST   = c_DB_W'(DEBOUNCE_CYC - 1);
    localparam logic [STAGES-1:0]   c_FIRST     = STAGES'(1);

    logic w_rst_int_n;

    rst_sync_2ff u_rst_sync (
        .clk     (clk),
        .i_rst_n (rst_n),
        .o_rst_n (w_rst_int_n)
    );

    // ------------------------------------------------------------------
    // Button synchronizer and debouncer
    // ------------------------------------------------------------------
    logic              r_btn_meta;
    logic              r_btn_sync;
    logic [c_DB_W-1:0] r_db_cnt;
    logic              r_press_q;
    logic              r_press_d;
    logic              w_btn_low;

    assign w_btn_low = ~r_btn_sync;

    // Synchronizer flops idle high so a released button never looks pressed.
    always_ff @(posedge clk or negedge w_rst_int_n) begin
        if (!w_rst_int_n) begin
            r_btn_meta <= 1'b1;
            r_btn_sync <= 1'b1;
            r_db_cnt   <= '0;
            r_press_q  <= 1'b0;
            r_press_d  <= 1'b0;
        end else begin
            r_btn_meta <= btn_n;
            r_btn_sync <= r_btn_meta;
            r_press_d  <= r_press_q;
            if (w_btn_low == r_press_q) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == c_DB_LAST) begin
                r_db_cnt  <= '0;
                r_press_q <= ~r_press_q;
            end else begin
                r_db_cnt <= r_db_cnt + c_DB_W'(1);
            end
        end
    end

    logic w_trig;
    assign w_trig = (r_press_q & ~r_press_d) | sw_rst_req;

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    state_t              r_state;
    logic [c_HOLD_W-1:0] r_hold_cnt;
    logic [c_STEP_W-1:0] r_step_cnt;
    logic [STAGES-1:0]   r_rst_out_n;
    logic                r_busy;
    logic                r_ack;
    logic                r_ack_pend;

    state_t              w_state_nx;
    logic [c_HOLD_W-1:0] w_hold_nx;
    logic [c_STEP_W-1:0] w_step_nx;
    logic [STAGES-1:0]   w_rst_nx;
    logic [STAGES-1:0]   w_shift;
    logic                w_busy_nx;
    logic                w_ack_nx;
    logic                w_ack_pend_nx;
    logic                w_enter_run;

    always_ff @(posedge clk or negedge w_rst_int_n) begin
        if (!w_rst_int_n) begin
            r_state     <= ST_HOLD;
            r_hold_cnt  <= '0;
            r_step_cnt  <= '0;
            r_rst_out_n <= '0;
            r_busy      <= 1'b1;
            r_ack       <= 1'b0;
            r_ack_pend  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_hold_cnt  <= w_hold_nx;
            r_step_cnt  <= w_step_nx;
            r_rst_out_n <= w_rst_nx;
            r_busy      <= w_busy_nx;
            r_ack       <= w_ack_nx;
            r_ack_pend  <= w_ack_pend_nx;
        end
    end

    // Released stages are always a contiguous run from bit 0, so the next
    // stage is released by shifting in a one.
    assign w_shift = (r_rst_out_n << 1) | c_FIRST;

    always_comb begin
        w_state_nx    = r_state;
        w_hold_nx     = r_hold_cnt;
        w_step_nx     = r_step_cnt;
        w_rst_nx      = r_rst_out_n;
        w_busy_nx     = r_busy;
        w_ack_nx      = 1'b0;
        w_ack_pend_nx = r_ack_pend | sw_rst_req;
        w_enter_run   = 1'b0;

        if (w_trig) begin
            w_state_nx = ST_HOLD;
            w_hold_nx  = '0;
            w_rst_nx   = '0;
            w_busy_nx  = 1'b1;
        end else begin
            case (r_state)
                ST_HOLD: begin
                    w_rst_nx  = '0;
                    w_busy_nx = 1'b1;
                    if (r_press_q) begin
                        w_hold_nx = '0;
                    end else if (r_hold_cnt == c_HOLD_LAST) begin
                        w_step_nx  = '0;
                        w_rst_nx   = c_FIRST;
                        w_state_nx = ST_RELEASE;
                        // A single-stage build is fully released here.
                        if (c_FIRST == '1) begin
                            w_enter_run = 1'b1;
                        end
                    end else begin
                        w_hold_nx = r_hold_cnt + c_HOLD_W'(1);
                    end
                end
                ST_RELEASE: begin
                    if (r_step_cnt == c_STEP_LAST) begin
                        w_step_nx = '0;
                        w_rst_nx  = w_shift;
                        if (w_shift == '1) begin
                            w_enter_run = 1'b1;
                        end
                    end else begin
                        w_step_nx = r_step_cnt + c_STEP_W'(1);
                    end
                end
                ST_RUN: begin
                    w_rst_nx  = '1;
                    w_busy_nx = 1'b0;
                end
                default: begin
                    w_state_nx = ST_HOLD;
                    w_hold_nx  = '0;
                    w_rst_nx   = '0;
                    w_busy_nx  = 1'b1;
                end
            endcase

            if (w_enter_run) begin
                w_state_nx    = ST_RUN;
                w_busy_nx     = 1'b0;
                w_ack_nx      = r_ack_pend;
                w_ack_pend_nx = 1'b0;
            end
        end
    end

    assign rst_out_n  = r_rst_out_n;
    assign busy       = r_busy;
    assign sw_rst_ack = r_ack;

endmodule
`default_nettype wire

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Reset source and sequencer that generates the per-domain reset requests consumed by our downstream reset synchronizers. It merges the power-on reset, a debounced external push-button and a software reset request. It then drives STAGES reset outputs that assert together and release in a fixed order with programmable hold and step delays. It sits at the top of the clock/reset tree, one instance per board clock.

Parameters:
DEBOUNCE_CYC, 16, consecutive stable cycles required to accept a button level change (>=2)
HOLD_CYC, 8, cycles all outputs stay asserted after the last trigger clears (>=1)
STEP_CYC, 4, cycles between successive stage releases (>=1)
STAGES, 3, number of sequenced reset outputs (1..8)

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
btn_n  in  1  raw push-button, asynchronous to clk, active-low, bouncy
sw_rst_req  in  1  single-cycle software reset request, synchronous to clk
sw_rst_ack  out  1  single-cycle pulse: software-requested sequence has completed
rst_out_n  out  STAGES  sequenced reset outputs, active-low, bit 0 released first
busy  out  1  high whenever any rst_out_n bit is low or a sequence is pending

Behaviour:
- Internal reset: rst_n passes through rst_sync_2ff. Assertion is asynchronous; release occurs on the 2nd clk rising edge after rst_n rises (edge E0). All state uses this internal reset.
- Reset values (internal reset asserted): rst_out_n = all 0, busy = 1, sw_rst_ack = 0, state = HOLD, hold_cnt = 0, press_q = 0, ack_pend = 0.
- btn_n: 2-flop synchronized, then debounced. press_q sets after DEBOUNCE_CYC consecutive synchronized-low samples and clears after DEBOUNCE_CYC consecutive highs. Any opposite sample restarts the counter.
- trigger = press_q rising edge OR sw_rst_req. Simultaneous button and software triggers form one event; ack_pend is set.
- All outputs are registered. No combinational path from any input to rst_out_n.
- States:
  - HOLD: rst_out_n = 0.
    - hold_cnt is held at 0 while press_q = 1 or trigger = 1; otherwise it increments.
    - When hold_cnt = HOLD_CYC-1 and no trigger: go to RELEASE, step_cnt = 0, stage = 0, and rst_out_n[0] = 1 on that edge.
  - RELEASE: step_cnt increments each cycle.
    - When step_cnt = STEP_CYC-1: set rst_out_n[stage+1], stage++, step_cnt = 0.
    - When the last bit is set: go to RUN on the same edge.
    - If STAGES = 1: go directly HOLD -> RUN.
  - RUN: rst_out_n = all 1, busy = 0.
  - Any state + trigger: next edge rst_out_n = all 0, state = HOLD, hold_cnt = 0. Release aborts mid-sequence; already-released stages reassert.
- Timing at defaults after power-on: rst_out_n[k] rises HOLD_CYC + k*STEP_CYC edges after E0, i.e. [0]@E8, [1]@E12, [2]@E16. busy falls at E16.
- busy deasserts on the same edge that the final rst_out_n bit rises.
- sw_rst_ack:
  - sw_rst_req sets ack_pend. A later button trigger keeps it set.
  - On entry to RUN with ack_pend = 1: sw_rst_ack pulses high for exactly 1 cycle and ack_pend clears.
  - Button-only sequences and power-on never pulse sw_rst_ack.
- sw_rst_req during HOLD restarts hold_cnt and does not produce a second ack.
- Button held low indefinitely: the block stays in HOLD. Release starts HOLD_CYC cycles after press_q clears.
- rst_n asserted mid-sequence: all outputs asynchronously reach their reset values, and ack_pend is lost.

Decomposition:
- Package rst_seq_pkg holds:
  - state enum {HOLD, RELEASE, RUN}, 2-bit encoding
  - a clog2-based counter-width function
  - default parameter constants
- Sub-module rst_sync_2ff (asynchronous-assert, synchronous-release, 2 flops) creates the internal reset. A plain 2-flop data synchronizer for btn_n is instantiated inline.

Test Plan:
- Power-on, defaults: release rst_n at t0 -> rst_out_n 000 until E8, then 001@E8, 011@E12, 111@E16; busy falls @E16; sw_rst_ack stays 0.
- Bouncy button: from RUN, btn_n toggles every 5 cycles for 60 cycles and then stays high -> no reset. btn_n then held low for 20 cycles -> rst_out_n = 000 exactly 2 + 16 + 1 cycles after the fall; release begins 8 cycles after press_q clears.
- Software reset: sw_rst_req pulse in RUN -> rst_out_n = 000 next edge; 001/011/111 at +9/+13/+17; sw_rst_ack high for exactly the cycle of the +17 edge.
- Abort mid-release: sw_rst_req when rst_out_n = 011 -> 000 next edge, full sequence restarts, exactly one sw_rst_ack.
- Repeated triggers in HOLD: sw_rst_req every 5 cycles for 30 cycles -> rst_out_n stays 000 throughout; first release occurs 9 cycles after the last request; exactly one ack.
- Asynchronous reset mid-sequence: rst_n low while rst_out_n = 001 -> rst_out_n = 000 with no clk edge required; after release the power-on timing repeats exactly.
